// File: rtl/h6_mul_sequencer_pkg.sv
// Shared definitions for the H6 multiplier sequencer: data width and FSM state encoding.
`timescale 1ns/1ps
package h6_mul_sequencer_pkg;

    localparam int DATA_W = 16;

    // Nine states do not fit the 3-bit binary encoding, so one more bit is used
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR    = 4'd1,
        S_LD_M   = 4'd2,
        S_LD_Q   = 4'd3,
        S_RUN    = 4'd4,
        S_SETTLE = 4'd5,
        S_OUT_A  = 4'd6,
        S_OUT_Q  = 4'd7,
        S_DONE   = 4'd8
    } seq_state_t;

    function automatic logic is_busy_state(input seq_state_t s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/h6_mul_sequencer_step_timer.sv
// Step/gap down-counters for the RUN phase; the gap counter is reused for the SETTLE wait.
`timescale 1ns/1ps
module h6_step_timer
    import h6_mul_sequencer_pkg::*;
#(
    parameter int N_STEPS    = 16,
    parameter int STEP_GAP   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic settle_en,
    output logic pulse,
    output logic last,
    output logic settle_last
);

    localparam int GAP_MAX = (STEP_GAP > SETTLE_CYC) ? STEP_GAP : SETTLE_CYC;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam int SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    logic [SW-1:0] step_cnt;
    logic [GW-1:0] gap_cnt;
    logic          period_end;

    // gap_cnt==0 marks a pulse cycle; a step period ends on its last gap cycle
    always_comb begin
        if (gap_cnt == '0) begin
            period_end = (STEP_GAP == 0);
        end else begin
            period_end = (gap_cnt == GW'(1));
        end
    end

    assign last        = en && period_end && (step_cnt == '0);
    assign pulse       = load || (en && period_end && !last);
    assign settle_last = settle_en && (gap_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            gap_cnt  <= '0;
        end else if (load) begin
            step_cnt <= SW'(N_STEPS - 1);
            gap_cnt  <= '0;
        end else if (en) begin
            if (last) begin
                step_cnt <= '0;
                gap_cnt  <= GW'(SETTLE_CYC - 1);
            end else if (period_end) begin
                step_cnt <= step_cnt - SW'(1);
                gap_cnt  <= '0;
            end else if (gap_cnt == '0) begin
                gap_cnt <= GW'(STEP_GAP);
            end else begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end else if (settle_en && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

endmodule

// File: rtl/h6_mul_sequencer.sv
// Upstream sequencer for the H6 multiplier: loads operands, steps it, then gates A/Q onto the S-bus.
// Optional feature: define H6_SEQ_ABORT_EN to add the abort input.
`timescale 1ns/1ps
module h6_mul_sequencer
    import h6_mul_sequencer_pkg::*;
#(
    parameter int N_STEPS    = 16,
    parameter int STEP_GAP   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic              CLK_50,
    input  logic              Rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              bus_gnt,
`ifdef H6_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [DATA_W-1:0] h6_data,
    output logic              h6_clr,
    output logic              h6_ld_m,
    output logic              h6_ld_q,
    output logic              h6_step,
    output logic              ALS_H6_a,
    output logic              ALS_H6_q,
    output logic              busy,
    output logic              done
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              abort_req;
    logic              tmr_pulse;
    logic              tmr_last;
    logic              tmr_settle_last;

    logic [DATA_W-1:0] data_n;
    logic              clr_n;
    logic              ld_m_n;
    logic              ld_q_n;
    logic              step_n;
    logic              als_a_n;
    logic              als_q_n;
    logic              busy_n;
    logic              done_n;

`ifdef H6_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    h6_step_timer #(
        .N_STEPS    (N_STEPS),
        .STEP_GAP   (STEP_GAP),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk         (CLK_50),
        .rst         (Rst),
        .load        (state == S_LD_Q),
        .en          (state == S_RUN),
        .settle_en   (state == S_SETTLE),
        .pulse       (tmr_pulse),
        .last        (tmr_last),
        .settle_last (tmr_settle_last)
    );

    always_ff @(posedge CLK_50 or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (start) next_state = S_CLR;
            S_CLR:    next_state = S_LD_M;
            S_LD_M:   next_state = S_LD_Q;
            S_LD_Q:   next_state = S_RUN;
            S_RUN:    if (tmr_last) next_state = S_SETTLE;
            S_SETTLE: if (tmr_settle_last) next_state = S_OUT_A;
            S_OUT_A:  if (bus_gnt) next_state = S_OUT_Q;
            S_OUT_Q:  if (bus_gnt) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort_req && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end
    end

    // Outputs are decoded from next_state and registered, so each strobe lines up with its state
    always_comb begin
        data_n  = '0;
        clr_n   = (next_state == S_CLR);
        ld_m_n  = (next_state == S_LD_M);
        ld_q_n  = (next_state == S_LD_Q);
        step_n  = (next_state == S_RUN) && tmr_pulse;
        als_a_n = (next_state == S_OUT_A);
        als_q_n = (next_state == S_OUT_Q);
        busy_n  = is_busy_state(next_state);
        done_n  = (next_state == S_DONE);
        if (next_state == S_LD_M) begin
            data_n = op_a_q;
        end else if (next_state == S_LD_Q) begin
            data_n = op_b_q;
        end
    end

    always_ff @(posedge CLK_50 or posedge Rst) begin
        if (Rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
        end
    end

    always_ff @(posedge CLK_50 or posedge Rst) begin
        if (Rst) begin
            h6_data  <= '0;
            h6_clr   <= 1'b0;
            h6_ld_m  <= 1'b0;
            h6_ld_q  <= 1'b0;
            h6_step  <= 1'b0;
            ALS_H6_a <= 1'b0;
            ALS_H6_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            h6_data  <= data_n;
            h6_clr   <= clr_n;
            h6_ld_m  <= ld_m_n;
            h6_ld_q  <= ld_q_n;
            h6_step  <= step_n;
            ALS_H6_a <= als_a_n;
            ALS_H6_q <= als_q_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_h6_mul_sequencer.sv
// Directed self-checking bench for h6_mul_sequencer, with a small H6 shift-add model on the strobes.
`timescale 1ns/1ps
module tb_h6_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start4;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        bus_gnt;
`ifdef H6_SEQ_ABORT_EN
    logic        abort;
    logic        abort4;
`endif

    logic [15:0] h6_data, h6_data4;
    logic        h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q, busy, done;
    logic        h6_clr4, h6_ld_m4, h6_ld_q4, h6_step4, als_a4, als_q4, busy4, done4;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] m_m, m_a, m_q;
    int          done_cyc, step_seen, als_a_cyc, als_q_cyc, multi_strobe, bad_data, not_busy;
    logic [15:0] ldm_data, ldq_data, bus_a, bus_q;

    always #5 clk = ~clk;

    h6_mul_sequencer dut (
        .CLK_50   (clk),
        .Rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .bus_gnt  (bus_gnt),
`ifdef H6_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .h6_data  (h6_data),
        .h6_clr   (h6_clr),
        .h6_ld_m  (h6_ld_m),
        .h6_ld_q  (h6_ld_q),
        .h6_step  (h6_step),
        .ALS_H6_a (ALS_H6_a),
        .ALS_H6_q (ALS_H6_q),
        .busy     (busy),
        .done     (done)
    );

    h6_mul_sequencer #(.N_STEPS(4), .STEP_GAP(0), .SETTLE_CYC(2)) dut4 (
        .CLK_50   (clk),
        .Rst      (rst),
        .start    (start4),
        .op_a     (op_a),
        .op_b     (op_b),
        .bus_gnt  (bus_gnt),
`ifdef H6_SEQ_ABORT_EN
        .abort    (abort4),
`endif
        .h6_data  (h6_data4),
        .h6_clr   (h6_clr4),
        .h6_ld_m  (h6_ld_m4),
        .h6_ld_q  (h6_ld_q4),
        .h6_step  (h6_step4),
        .ALS_H6_a (als_a4),
        .ALS_H6_q (als_q4),
        .busy     (busy4),
        .done     (done4)
    );

    // Reference H6 datapath: each strobe seen in a cycle acts at the following edge
    task automatic h6_model_edge();
        logic [16:0] sum;
        logic [32:0] t;
        if (h6_clr)  m_a = '0;
        if (h6_ld_m) m_m = h6_data;
        if (h6_ld_q) m_q = h6_data;
        if (h6_step) begin
            sum = m_q[0] ? ({1'b0, m_a} + {1'b0, m_m}) : {1'b0, m_a};
            t   = {sum, m_q} >> 1;
            m_a = t[31:16];
            m_q = t[15:0];
        end
    endtask

    // Runs one operation on the main DUT; stall = grant-low cycles in OUT_A, poke = cycle to pulse start with FFFF
    task automatic run_seq(input logic [15:0] a, input logic [15:0] b, input int stall, input int poke);
        int cyc;
        int stall_left;
        op_a = a; op_b = b; bus_gnt = 1'b1; start = 1'b1;
        m_m = '0; m_a = '0; m_q = '0;
        done_cyc = -1; step_seen = 0; als_a_cyc = 0; als_q_cyc = 0;
        multi_strobe = 0; bad_data = 0; not_busy = 0;
        ldm_data = 16'hDEAD; ldq_data = 16'hDEAD; bus_a = 16'hDEAD; bus_q = 16'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        stall_left = stall;
        while (done_cyc < 0 && cyc <= 200) begin
            if ($countones({h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q}) > 1) multi_strobe++;
            if (h6_ld_m) ldm_data = h6_data;
            else if (h6_ld_q) ldq_data = h6_data;
            else if (h6_data != 16'h0000) bad_data++;
            if (h6_step) step_seen++;
            if (ALS_H6_a) begin als_a_cyc++; bus_a = m_a; end
            if (ALS_H6_q) begin als_q_cyc++; bus_q = m_q; end
            if (!busy) not_busy++;
            if (done) done_cyc = cyc;
            h6_model_edge();
            start = (cyc == poke);
            if (cyc == poke) begin op_a = 16'hFFFF; op_b = 16'hFFFF; end
            if (ALS_H6_a && stall_left > 0) begin bus_gnt = 1'b0; stall_left--; end
            else bus_gnt = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus_gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++;
        if ({h6_data, h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q, busy, done} !== 25'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {h6_data, h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op_a = 16'h0003; op_b = 16'h0005; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        tests_run++;
        if (h6_step !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_prestep: got step=%b busy=%b expected step=1 busy=1", h6_step, busy);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({h6_data, h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q, busy, done} !== 25'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midrun: got %h expected 0", {h6_data, h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_basic();
        run_seq(16'h0003, 16'h0005, 0, -1);
        tests_run++;
        if (done_cyc !== 40) begin tests_failed++; $display("[TB] FAIL basic_done_cycle: got %0d expected 40", done_cyc); end
        tests_run++;
        if (ldm_data !== 16'h0003 || ldq_data !== 16'h0005) begin
            tests_failed++; $display("[TB] FAIL basic_load_data: got %h/%h expected 0003/0005", ldm_data, ldq_data);
        end
        tests_run++;
        if (step_seen !== 16) begin tests_failed++; $display("[TB] FAIL basic_steps: got %0d expected 16", step_seen); end
        tests_run++;
        if (bus_a !== 16'h0000 || bus_q !== 16'h000F) begin
            tests_failed++; $display("[TB] FAIL basic_product: got A=%h Q=%h expected A=0000 Q=000F", bus_a, bus_q);
        end
        tests_run++;
        if (als_a_cyc !== 1 || als_q_cyc !== 1) begin
            tests_failed++; $display("[TB] FAIL basic_als: got a=%0d q=%0d expected 1 1", als_a_cyc, als_q_cyc);
        end
        tests_run++;
        if (multi_strobe !== 0 || bad_data !== 0 || not_busy !== 0) begin
            tests_failed++; $display("[TB] FAIL basic_hygiene: got multi=%0d data=%0d idle=%0d expected 0 0 0", multi_strobe, bad_data, not_busy);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL basic_after: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_grant_stall();
        run_seq(16'h0003, 16'h0005, 5, -1);
        tests_run++;
        if (done_cyc !== 45) begin tests_failed++; $display("[TB] FAIL stall_done_cycle: got %0d expected 45", done_cyc); end
        tests_run++;
        if (als_a_cyc !== 6 || als_q_cyc !== 1) begin
            tests_failed++; $display("[TB] FAIL stall_als: got a=%0d q=%0d expected 6 1", als_a_cyc, als_q_cyc);
        end
        tests_run++;
        if (multi_strobe !== 0 || bus_q !== 16'h000F) begin
            tests_failed++; $display("[TB] FAIL stall_result: got multi=%0d Q=%h expected 0 000F", multi_strobe, bus_q);
        end
    endtask

    task automatic test_start_while_busy();
        run_seq(16'h0003, 16'h0005, 0, 10);
        tests_run++;
        if (done_cyc !== 40 || bus_q !== 16'h000F || bus_a !== 16'h0000) begin
            tests_failed++; $display("[TB] FAIL busy_start_run: got done=%0d A=%h Q=%h expected 40 0000 000F", done_cyc, bus_a, bus_q);
        end
        repeat (2) begin
            tests_run++;
            if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_start_queued: got busy=%b expected 0", busy); end
            @(posedge clk); #1;
        end
        run_seq(16'h0003, 16'h0005, 0, 1);
        tests_run++;
        if (ldm_data !== 16'h0003 || ldq_data !== 16'h0005 || bus_q !== 16'h000F) begin
            tests_failed++; $display("[TB] FAIL busy_start_clr: got %h/%h Q=%h expected 0003/0005 000F", ldm_data, ldq_data, bus_q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_seq(16'h1234, 16'h0010, 0, -1);
        tests_run++;
        if (done_cyc !== 40 || bus_a !== 16'h0001 || bus_q !== 16'h2340) begin
            tests_failed++; $display("[TB] FAIL b2b_first: got done=%0d A=%h Q=%h expected 40 0001 2340", done_cyc, bus_a, bus_q);
        end
        run_seq(16'hFFFF, 16'hFFFF, 0, -1);
        tests_run++;
        if (done_cyc !== 40 || bus_a !== 16'hFFFE || bus_q !== 16'h0001) begin
            tests_failed++; $display("[TB] FAIL b2b_second: got done=%0d A=%h Q=%h expected 40 FFFE 0001", done_cyc, bus_a, bus_q);
        end
    endtask

    task automatic test_short_params();
        int cyc, n, first, lastc, dc;
        n = 0; first = -1; lastc = -1; dc = -1;
        bus_gnt = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 1;
        while (dc < 0 && cyc <= 60) begin
            if (h6_step4) begin n++; if (first < 0) first = cyc; lastc = cyc; end
            if (done4) dc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (n !== 4 || first !== 4 || lastc !== 7) begin
            tests_failed++; $display("[TB] FAIL short_steps: got n=%0d first=%0d last=%0d expected 4 4 7", n, first, lastc);
        end
        tests_run++;
        if (dc !== 12) begin tests_failed++; $display("[TB] FAIL short_done_cycle: got %0d expected 12", dc); end
    endtask

`ifdef H6_SEQ_ABORT_EN
    task automatic test_abort();
        int seen_done, seen_als;
        seen_done = 0; seen_als = 0;
        op_a = 16'h0003; op_b = 16'h0005; bus_gnt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (done) seen_done++;
            if (ALS_H6_a || ALS_H6_q) seen_als++;
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        if (done) seen_done++;
        tests_run++;
        if (busy !== 1'b0 || {h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q} !== 6'd0) begin
            tests_failed++; $display("[TB] FAIL abort_idle: got busy=%b strobes=%b expected 0 000000", busy, {h6_clr, h6_ld_m, h6_ld_q, h6_step, ALS_H6_a, ALS_H6_q});
        end
        tests_run++;
        if (seen_done !== 0 || seen_als !== 0) begin
            tests_failed++; $display("[TB] FAIL abort_no_done: got done=%0d als=%0d expected 0 0", seen_done, seen_als);
        end
        @(posedge clk); #1;
        run_seq(16'h0003, 16'h0005, 0, -1);
        tests_run++;
        if (done_cyc !== 40 || bus_q !== 16'h000F) begin
            tests_failed++; $display("[TB] FAIL abort_restart: got done=%0d Q=%h expected 40 000F", done_cyc, bus_q);
        end
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || h6_clr !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL abort_start_prio: got busy=%b clr=%b expected 1 1", busy, h6_clr);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_in_clr: got busy=%b expected 0", busy); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; op_a = '0; op_b = '0; bus_gnt = 1'b1;
`ifdef H6_SEQ_ABORT_EN
        abort = 1'b0; abort4 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_grant_stall();
        test_start_while_busy();
        test_back_to_back();
        test_short_params();
`ifdef H6_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
